video_fetch: RTL and testbench
==============================

// Module: video_fetch
// PURPOSE
//  Downstream consumer of the SRAM controller's video port. Generates VGA timing and
//  drives video_addr, one 64-bit word (8 pixels at 8bpp) ahead of the beam. After a
//  fixed wait, captures video_din into a prefetch buffer and serializes it to a
//  registered pixel stream with aligned de/hsync/vsync for the palette/DAC stage.
// PARAMETERS
//  H_ACTIVE   640        visible pixels per line; must be a multiple of 8
//  H_FP/H_SYNC/H_BP  16/96/48   horizontal front porch / sync / back porch, in pixels
//  V_ACTIVE   480        visible lines
//  V_FP/V_SYNC/V_BP  10/2/33    vertical front porch / sync / back porch, in lines
//  FB_BASE    24'h000000 byte address of pixel (0,0); bits [2:0] must be 0
//  FETCH_LAT  10         clk cycles from a video_addr change to video_din being valid
// PORTS
//  clk         in   1   system clock (same clock as the SRAM controller)
//  reset_n     in   1   synchronous, active-low reset
//  pix_ce      in   1   pixel tick enable; all timing advances only when pix_ce=1
//  video_addr  out  24  byte address of the requested 64-bit word; [2:0] always 0
//  video_din   in   64  word returned by the SRAM controller (its video_dout)
//  pixel       out  8   palette index of the current pixel; 0 outside active area
//  de          out  1   display enable, high during visible pixels
//  hsync       out  1   horizontal sync, active low
//  vsync       out  1   vertical sync, active low
//  frame_start out  1   one-clk pulse on the pix_ce tick where (hcount,vcount)=(0,0)
// BEHAVIOUR
//  Reset (reset_n=0 at posedge clk): hcount=vcount=0; pixel=0, de=0, hsync=1, vsync=1,
//   frame_start=0; video_addr=FB_BASE; line_base=FB_BASE; shift/nxt buffers=0;
//   fetch FSM in F_WAIT with counter=FETCH_LAT, so word 0 of line 0 is prefetched.
//   Reset mid-fetch aborts the fetch; no partial data is used.
//  Timing: hcount 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP), vcount 0..V_TOTAL-1;
//   both wrap to 0. Visible iff hcount<H_ACTIVE && vcount<V_ACTIVE. hsync low for
//   hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync low for the analogous vcount range.
//  Output pipeline: de/hsync/vsync/pixel are registered on the same pix_ce tick from the
//   same counter values, so they are mutually aligned with one pix_ce tick of latency.
//  Pixel order: pixel k (k=hcount[2:0]) of a word = video_din[8k+7:8k] (lowest byte first).
//  Word load: on a visible tick with hcount[2:0]==0, shift<=nxt and the pixel is taken
//   from nxt[7:0]; on other visible ticks, shift moves right by 8 bits.
//  Address sequencing (all on pix_ce ticks):
//   - visible tick, hcount[2:0]==0, word j=hcount/8 < H_ACTIVE/8-1:
//     video_addr<=line_base+8*(j+1); start fetch.
//   - tick at hcount==H_ACTIVE: the next line is v'=(vcount+1) mod V_TOTAL. If v'<V_ACTIVE,
//     line_base<=(v'==0 ? FB_BASE : line_base+H_ACTIVE) and video_addr<=that value;
//     start fetch. Otherwise video_addr is held.
//   - no other ticks change video_addr; it is stable between fetch starts.
//  Fetch FSM (runs on clk, not on pix_ce):
//   F_IDLE  -> F_WAIT on start; cnt<=FETCH_LAT-1.
//   F_WAIT  -> decrement cnt each clk; at cnt==0 go to F_LATCH.
//   F_LATCH -> nxt<=video_din; go to F_IDLE.
//   A start arriving in F_WAIT/F_LATCH restarts F_WAIT; the earlier fetch is discarded.
//  Constraint (not checked in RTL): 8 pix_ce periods >= FETCH_LAT+2 clk, so every fetch
//   completes before its word is loaded. pix_ce every 2nd clk meets this at defaults.
//  frame_start pulses exactly once per frame, for one clk.
// TESTING
//  1 Reset: hold reset_n=0 for 3 clk -> pixel=0, de=0, hsync=1, vsync=1, video_addr=FB_BASE.
//  2 Small timing (H_ACTIVE=16, H_FP=H_SYNC=H_BP=2, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1),
//    pix_ce every 2 clk -> 22 ticks per line, hsync low for exactly 2 ticks, de high 16 ticks/line.
//  3 SRAM model returning word at byte addr A = {8{A[7:0]}}+{8'd7,...,8'd0} per byte
//    -> line 0 pixels are 0..15, line 1 pixels are 16..31 in order, de-aligned.
//  4 Address trace: video_addr sequence per frame = 0,8 (line 0), 16,24 (line 1),
//    then 0 at the last line's hcount==H_ACTIVE; never a non-multiple of 8.
//  5 FETCH_LAT=10, pix_ce every 2 clk, SRAM model delaying data 10 clk -> no wrong pixel;
//    model delaying 12 clk -> mismatch detected (margin check).
//  6 Assert reset_n=0 mid-line for 1 clk -> next frame identical to test 3, frame_start
//    at the first (0,0) tick after release.

Source files
------------

// File: rtl/video_fetch.sv
// video_fetch: VGA timing with one-word-ahead framebuffer prefetch and an 8bpp pixel serializer.
module video_fetch #(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter logic [23:0] FB_BASE   = 24'h000000,
  parameter int          FETCH_LAT = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_ce,
  output logic [23:0] video_addr,
  input  logic [63:0] video_din,
  output logic [7:0]  pixel,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int CW = $clog2(FETCH_LAT + 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 8);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_END  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_END  = VW'(V_TOTAL - 1);

  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_LATCH} fstate_t;

  fstate_t       st_q;
  logic [CW-1:0] cnt_q;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d, v_nxt;
  logic [23:0]   line_base_q, addr_q, line_d;
  logic [63:0]   shift_q, nxt_q, shift_d;
  logic [7:0]    pixel_q, pixel_d;
  logic          de_q, hsync_q, vsync_q, fs_q;
  logic          visible, word_edge, start_word, start_line, fetch_start;

  always_comb begin
    visible     = (h_q < H_ACT) && (v_q < V_ACT);
    word_edge   = h_q[2:0] == 3'd0;
    h_d         = (h_q == H_END) ? '0 : h_q + 1'b1;
    v_nxt       = (v_q == V_END) ? '0 : v_q + 1'b1;
    v_d         = (h_q == H_END) ? v_nxt : v_q;
    start_word  = pix_ce && visible && word_edge && (h_q < H_LAST);
    start_line  = pix_ce && (h_q == H_ACT) && (v_nxt < V_ACT);
    fetch_start = start_word || start_line;
    line_d      = (v_nxt == '0) ? FB_BASE : line_base_q + 24'(H_ACTIVE);
    // the word boundary tick takes its pixel straight from the prefetch buffer
    pixel_d     = !visible ? 8'd0 : word_edge ? nxt_q[7:0] : shift_q[15:8];
    shift_d     = !visible ? shift_q : word_edge ? nxt_q : shift_q >> 8;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_q         <= '0;
      v_q         <= '0;
      line_base_q <= FB_BASE;
      addr_q      <= FB_BASE;
      shift_q     <= '0;
      pixel_q     <= '0;
      de_q        <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      fs_q        <= 1'b0;
    end else begin
      fs_q <= pix_ce && (h_q == '0) && (v_q == '0);
      if (pix_ce) begin
        h_q     <= h_d;
        v_q     <= v_d;
        shift_q <= shift_d;
        pixel_q <= pixel_d;
        de_q    <= visible;
        hsync_q <= !((h_q >= H_SS) && (h_q < H_SE));
        vsync_q <= !((v_q >= V_SS) && (v_q < V_SE));
        if (start_word) addr_q <= line_base_q + 24'(h_q) + 24'd8;
        if (start_line) begin
          line_base_q <= line_d;
          addr_q      <= line_d;
        end
      end
    end
  end

  // a new start always wins, so a superseded fetch never reaches the buffer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q  <= F_WAIT;
      cnt_q <= CW'(FETCH_LAT);
      nxt_q <= '0;
    end else if (fetch_start) begin
      st_q  <= F_WAIT;
      cnt_q <= CW'(FETCH_LAT - 1);
    end else if (st_q == F_WAIT) begin
      if (cnt_q == '0) st_q <= F_LATCH;
      else cnt_q <= cnt_q - 1'b1;
    end else if (st_q == F_LATCH) begin
      nxt_q <= video_din;
      st_q  <= F_IDLE;
    end
  end

  assign video_addr  = addr_q;
  assign pixel       = pixel_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_video_fetch.sv
// tb_video_fetch: scoreboard bench on a reduced 22x5 raster with a delayed-SRAM model.
module tb_video_fetch;
  localparam int HA = 16, HT = 22, VA = 2, VT = 5;

  logic        clk = 1'b0, reset_n = 1'b0, pix_ce = 1'b0;
  logic [23:0] video_addr;
  logic [63:0] video_din;
  logic [7:0]  pixel;
  logic        de, hsync, vsync, frame_start;

  int vectors = 0, miscompares = 0, margin_err = 0, delay = 10;
  bit margin_mode = 0;
  int mh = 0, mv = 0, frames = 0;
  logic [23:0] hist [16];

  typedef struct {
    logic [7:0]  pix;
    logic        de, hs, vs, fs;
    logic [23:0] addr;
    bit          chk_pix;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  video_fetch #(
    .H_ACTIVE(HA), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(VA), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FB_BASE(24'h000000), .FETCH_LAT(10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .video_addr(video_addr),
    .video_din(video_din), .pixel(pixel), .de(de), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start)
  );

  function automatic logic [63:0] word_at(logic [23:0] a);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = a[7:0] + 8'(k);
    return w;
  endfunction

  // SRAM model: data for an address appears 'delay' clocks after the address changes
  always @(posedge clk) begin
    hist[0] <= video_addr;
    for (int i = 1; i < 16; i++) hist[i] <= hist[i-1];
  end
  assign video_din = word_at(hist[delay-1]);

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(int h, int v, int f);
    exp_t e;
    e.de      = (h < HA) && (v < VA);
    e.pix     = e.de ? 8'(v * HA + h) : 8'd0;
    e.hs      = !(h >= 18 && h < 20);
    e.vs      = (v != 3);
    e.fs      = (h == 0) && (v == 0);
    e.addr    = (v == 0) ? ((h < HA) ? 24'd8 : 24'd16) :
                (v == VT - 1 && h >= HA) ? 24'd0 : 24'd24;
    e.chk_pix = (f >= 1);
    return e;
  endfunction

  task automatic tick();
    sb.push_back(model(mh, mv, frames));
    pix_ce = 1'b1;
    @(negedge clk);
    pix_ce = 1'b0;
    @(negedge clk);
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) begin
        mv = 0;
        frames++;
      end
    end
  endtask

  task automatic do_reset(int n);
    reset_n = 1'b0;
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
    mh = 0;
    mv = 0;
    frames = 0;
    sb.delete();
  endtask

  initial forever begin
    @(posedge clk);
    if (reset_n && pix_ce) begin
      #1;
      if (sb.size() == 0) check("sb_underflow", 0, 1);
      else begin
        mon_e = sb.pop_front();
        check("de", de, mon_e.de);
        check("hsync", hsync, mon_e.hs);
        check("vsync", vsync, mon_e.vs);
        check("frame_start", frame_start, mon_e.fs);
        check("video_addr", video_addr, mon_e.addr);
        if (mon_e.chk_pix) begin
          if (margin_mode) margin_err += int'(pixel !== mon_e.pix);
          else check("pixel", pixel, mon_e.pix);
        end
      end
    end else if (reset_n) begin
      #1;
      check("fs_idle", frame_start, 0);
    end
  end

  initial begin
    reset_n = 1'b0;
    pix_ce  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pixel", pixel, 0);
    check("rst_de", de, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_addr", video_addr, 0);
    check("rst_fs", frame_start, 0);
    reset_n = 1'b1;
    repeat (3 * HT * VT) tick();
    repeat (HT + 5) tick();
    do_reset(1);
    repeat (2 * HT * VT) tick();
    delay = 12;
    margin_mode = 1;
    do_reset(3);
    repeat (2 * HT * VT) tick();
    check("margin_detect", margin_err != 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
